sram_arb: RTL and testbench
===========================

Name: sram_arb

Overview:
- Arbiter that shares the external 16-bit asynchronous SRAM between the acquisition sample writer (acq_waddr/acq_wdata/acq_wen) and the host readout path.
- Acquisition writes have absolute priority and cannot be back-pressured. They are absorbed in a small write FIFO.
- Host reads use a req/ack + valid handshake and are served only in write-free gaps.
- Sits between acq and the top-level SRAM pins; the host-side bridge drives the read port.

Parameters:
- RAM_DATA_W, 16, SRAM data bus width.
- RAM_ADDR_W, 19, SRAM address width.
- WBUF_DEPTH, 4, write FIFO depth (power of 2, ≥2).
- RD_CYCLES, 2, clocks ram_oe_n is held low per read (≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- acq_waddr  in  RAM_ADDR_W  acquisition write address
- acq_wdata  in  RAM_DATA_W  acquisition write data
- acq_wen  in  1  write strobe, one word per high cycle, no backpressure
- acq_busy  in  1  acquisition in progress; blocks host read grants
- host_rreq  in  1  host read request (level; held with address until ack)
- host_raddr  in  RAM_ADDR_W  host read address
- host_rack  out  1  one-cycle pulse: request accepted
- host_rdata  out  RAM_DATA_W  read data
- host_rvalid  out  1  one-cycle pulse: host_rdata valid
- wr_ovf  out  1  sticky write-FIFO overflow flag
- ovf_clr  in  1  clears wr_ovf
- ram_addr  out  RAM_ADDR_W  SRAM address
- ram_dout  out  RAM_DATA_W  SRAM write data
- ram_doe  out  1  SRAM data bus output enable (tristate control at top)
- ram_din  in  RAM_DATA_W  SRAM read data
- ram_ce_n  out  1  chip enable, active low
- ram_we_n  out  1  write enable, active low
- ram_oe_n  out  1  output enable, active low

Behaviour:
- Reset (async, rst_n low) values:
  - ram_ce_n = ram_we_n = ram_oe_n = 1; ram_doe = 0; ram_addr = 0; ram_dout = 0.
  - host_rack = host_rvalid = 0; host_rdata = 0; wr_ovf = 0.
  - FIFO empty; FSM in IDLE.
- Reset mid-operation aborts the current access and discards FIFO contents.
- All outputs are registered.
- Write FIFO:
  - Pushes {acq_waddr, acq_wdata} on acq_wen.
  - Push and pop in the same cycle are allowed at any fill level, including full.
  - acq_wen while full with no pop in that cycle: word is dropped and wr_ovf is set the next cycle.
  - wr_ovf holds until ovf_clr. If ovf_clr and a new overflow occur in the same cycle, set wins.
- FSM states:
  - IDLE: all strobes inactive.
    - FIFO non-empty → WRITE.
    - Else if host_rreq && !acq_busy → READ: latch host_raddr, pulse host_rack.
  - WRITE (one clock per word): pop head; ram_addr/ram_dout = head; ram_ce_n = 0, ram_we_n = 0, ram_doe = 1.
    - Stays in WRITE while the FIFO stays non-empty (back-to-back, one word/clock).
    - Else → IDLE.
  - READ: ram_ce_n = 0, ram_oe_n = 0, ram_doe = 0 for RD_CYCLES clocks.
    - ram_din is sampled on the last of those clocks.
    - host_rdata updated and host_rvalid pulsed on the following clock.
    - Then → TURN.
  - TURN: one clock, all strobes inactive, ram_doe = 0 (bus turnaround), then → IDLE.
- A read is never preempted. Writes arriving during READ/TURN queue in the FIFO.
  - WBUF_DEPTH ≥ RD_CYCLES+2 guarantees no loss at one write per clock.
- Read latency: host_rack at IDLE+1; host_rvalid exactly RD_CYCLES+1 clocks after host_rack.
- ram_doe is never high while ram_oe_n is low. A WRITE never directly follows READ without TURN.
- A read can only be granted when the FIFO is empty, so after host_rack, host_raddr may change freely.
- Writes issue in FIFO (arrival) order. Address wrap-around is not handled here; acq owns addressing.

Test Plan:
- Reset: hold rst_n=0 mid-WRITE burst → all strobes 1, ram_doe=0, FIFO empty, wr_ovf=0 asynchronously. After release, FSM stays IDLE with no acq_wen.
- Write burst: acq_wen for 100 consecutive clocks, addr 0..99, data 0x200+i → 100 SRAM writes, in order, one per clock, data matching; wr_ovf stays 0.
- Read, RD_CYCLES=2: write 0xABCD to addr 0x12345, then host_rreq with addr 0x12345 → host_rack 1 clk after IDLE; host_rvalid 3 clks after ack; host_rdata=0xABCD.
- Collision: acq_wen continuous starting the clock after host_rack → the read completes, then TURN, then writes drain with no loss. FIFO peak ≤ RD_CYCLES+2; all words written in order.
- Lock/overflow:
  - acq_busy=1 with host_rreq held → no host_rack until acq_busy falls.
  - With WBUF_DEPTH=2, RD_CYCLES=4, stream writes during a read → wr_ovf=1, dropped words absent; ovf_clr → wr_ovf=0.

Source files
------------

// File: rtl/sram_arb_if.sv
// ---------------------------------------------------------------------------
// sram_arb_if : acquisition write port and host read port of the SRAM arbiter
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sram_arb_if #(
    parameter int RAM_DATA_W = 16,
    parameter int RAM_ADDR_W = 19
);
    logic [RAM_ADDR_W-1:0] acq_waddr;
    logic [RAM_DATA_W-1:0] acq_wdata;
    logic                  acq_wen;
    logic                  acq_busy;
    logic                  host_rreq;
    logic [RAM_ADDR_W-1:0] host_raddr;
    logic                  host_rack;
    logic [RAM_DATA_W-1:0] host_rdata;
    logic                  host_rvalid;
    logic                  wr_ovf;
    logic                  ovf_clr;

    modport slave (
        input  acq_waddr, acq_wdata, acq_wen, acq_busy,
        input  host_rreq, host_raddr, ovf_clr,
        output host_rack, host_rdata, host_rvalid, wr_ovf
    );

    modport master (
        output acq_waddr, acq_wdata, acq_wen, acq_busy,
        output host_rreq, host_raddr, ovf_clr,
        input  host_rack, host_rdata, host_rvalid, wr_ovf
    );
endinterface

`default_nettype wire

// File: rtl/sram_arb.sv
// ---------------------------------------------------------------------------
// sram_arb : write-priority arbiter sharing an async SRAM between acq and host
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_arb #(
    parameter int RAM_DATA_W = 16,
    parameter int RAM_ADDR_W = 19,
    parameter int WBUF_DEPTH = 4,
    parameter int RD_CYCLES  = 2
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    sram_arb_if.slave                  bus,
    output logic [RAM_ADDR_W-1:0]      ram_addr_o,
    output logic [RAM_DATA_W-1:0]      ram_dout_o,
    output logic                       ram_doe_o,
    input  wire logic [RAM_DATA_W-1:0] ram_din_i,
    output logic                       ram_ce_n_o,
    output logic                       ram_we_n_o,
    output logic                       ram_oe_n_o
);
    localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int ENT_W = RAM_ADDR_W + RAM_DATA_W;
    localparam int CNT_W = (RD_CYCLES > 1) ? $clog2(RD_CYCLES) : 1;
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(WBUF_DEPTH);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_TURN} state_t;

    state_t                  state_q, state_d;
    logic [ENT_W-1:0]        mem_q [WBUF_DEPTH];
    logic [PTR_W-1:0]        wptr_q, rptr_q;
    logic [PTR_W:0]          cnt_q, cnt_d;
    logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;
    logic                    ovf_q;
    logic                    ce_n_q, ce_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
    logic                    doe_q, doe_d, rack_q, rack_d;
    logic [RAM_ADDR_W-1:0]   addr_q, addr_d;
    logic [RAM_DATA_W-1:0]   dout_q, dout_d;
    logic                    smp_q, rvalid_q;
    logic [RAM_DATA_W-1:0]   din_q, rdata_q;

    logic                    w_empty, w_full, w_push, w_pop, w_drop, w_rd_last;
    logic [ENT_W-1:0]        w_head;

    assign w_empty   = (cnt_q == '0);
    assign w_full    = (cnt_q == FULL_CNT);
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_push    = bus.acq_wen && (!w_full || w_pop);
    assign w_drop    = bus.acq_wen && w_full && !w_pop;
    assign w_head    = mem_q[rptr_q];
    assign w_rd_last = (state_q == S_READ) && (rd_cnt_q == RD_LAST);

    always_comb begin
        cnt_d = cnt_q;
        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wptr_q] <= {bus.acq_waddr, bus.acq_wdata};
    end

    // Strobes are computed for the next state and registered alongside it.
    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        w_pop    = 1'b0;
        ce_n_d   = 1'b1;
        we_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        doe_d    = 1'b0;
        rack_d   = 1'b0;
        addr_d   = addr_q;
        dout_d   = dout_q;
        case (state_q)
            S_IDLE, S_WRITE: begin
                if (!w_empty) begin
                    state_d          = S_WRITE;
                    w_pop            = 1'b1;
                    {addr_d, dout_d} = w_head;
                    ce_n_d           = 1'b0;
                    we_n_d           = 1'b0;
                    doe_d            = 1'b1;
                end else if (state_q == S_IDLE && bus.host_rreq && !bus.acq_busy) begin
                    state_d  = S_READ;
                    addr_d   = bus.host_raddr;
                    rd_cnt_d = '0;
                    ce_n_d   = 1'b0;
                    oe_n_d   = 1'b0;
                    rack_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (rd_cnt_q == RD_LAST) begin
                    state_d = S_TURN;
                end else begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    ce_n_d   = 1'b0;
                    oe_n_d   = 1'b0;
                end
            end
            S_TURN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            rd_cnt_q <= '0;
            ovf_q    <= 1'b0;
            ce_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            doe_q    <= 1'b0;
            rack_q   <= 1'b0;
            addr_q   <= '0;
            dout_q   <= '0;
            smp_q    <= 1'b0;
            din_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_cnt_q <= rd_cnt_d;
            ce_n_q   <= ce_n_d;
            we_n_q   <= we_n_d;
            oe_n_q   <= oe_n_d;
            doe_q    <= doe_d;
            rack_q   <= rack_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            if (w_push) wptr_q <= wptr_q + PTR_W'(1);
            if (w_pop)  rptr_q <= rptr_q + PTR_W'(1);
            if (w_drop)           ovf_q <= 1'b1;
            else if (bus.ovf_clr) ovf_q <= 1'b0;
            // Read data is captured at the end of the last OE-low clock, then presented.
            smp_q    <= w_rd_last;
            if (w_rd_last) din_q <= ram_din_i;
            rvalid_q <= smp_q;
            if (smp_q) rdata_q <= din_q;
        end
    end

    assign ram_addr_o      = addr_q;
    assign ram_dout_o      = dout_q;
    assign ram_doe_o       = doe_q;
    assign ram_ce_n_o      = ce_n_q;
    assign ram_we_n_o      = we_n_q;
    assign ram_oe_n_o      = oe_n_q;
    assign bus.host_rack   = rack_q;
    assign bus.host_rdata  = rdata_q;
    assign bus.host_rvalid = rvalid_q;
    assign bus.wr_ovf      = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_arb.sv
// ---------------------------------------------------------------------------
// tb_sram_arb : directed bench for sram_arb (default and shallow-FIFO builds)
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sram_arb;
    localparam int AW = 19;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sram_arb_if #(.RAM_DATA_W(DW), .RAM_ADDR_W(AW)) bus_a ();
    sram_arb_if #(.RAM_DATA_W(DW), .RAM_ADDR_W(AW)) bus_b ();

    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_dout, b_dout, a_din, b_din;
    logic a_doe, a_ce_n, a_we_n, a_oe_n;
    logic b_doe, b_ce_n, b_we_n, b_oe_n;

    sram_arb #(.RAM_DATA_W(DW), .RAM_ADDR_W(AW), .WBUF_DEPTH(4), .RD_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a),
        .ram_addr_o(a_addr), .ram_dout_o(a_dout), .ram_doe_o(a_doe), .ram_din_i(a_din),
        .ram_ce_n_o(a_ce_n), .ram_we_n_o(a_we_n), .ram_oe_n_o(a_oe_n)
    );

    sram_arb #(.RAM_DATA_W(DW), .RAM_ADDR_W(AW), .WBUF_DEPTH(2), .RD_CYCLES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b),
        .ram_addr_o(b_addr), .ram_dout_o(b_dout), .ram_doe_o(b_doe), .ram_din_i(b_din),
        .ram_ce_n_o(b_ce_n), .ram_we_n_o(b_we_n), .ram_oe_n_o(b_oe_n)
    );

    // Simple SRAM models, 4K words aliased on the low address bits.
    logic [DW-1:0] mem_a [4096];
    logic [DW-1:0] mem_b [4096];
    assign a_din = (!a_ce_n && !a_oe_n) ? mem_a[a_addr[11:0]] : '0;
    assign b_din = (!b_ce_n && !b_oe_n) ? mem_b[b_addr[11:0]] : '0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            c;
    } wr_t;

    wr_t           log_a[$];
    wr_t           log_b[$];
    int            cyc = 0;
    int            viol_a = 0;
    bit            prev_oe_a = 1'b0;
    int            rv_cnt_a = 0;
    int            rv_cyc_a = 0;
    logic [DW-1:0] rv_data_a = '0;
    int            passed = 0;
    int            total = 0;

    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (!a_ce_n && !a_we_n) begin
            e.a = a_addr; e.d = a_dout; e.c = cyc;
            log_a.push_back(e);
            mem_a[a_addr[11:0]] = a_dout;
        end
        if (!b_ce_n && !b_we_n) begin
            e.a = b_addr; e.d = b_dout; e.c = cyc;
            log_b.push_back(e);
            mem_b[b_addr[11:0]] = b_dout;
        end
        if (a_doe && !a_oe_n) viol_a++;
        if (!a_we_n && prev_oe_a) viol_a++;
        prev_oe_a = !a_oe_n;
        if (bus_a.host_rvalid) begin
            rv_cnt_a++;
            rv_cyc_a  = cyc;
            rv_data_a = bus_a.host_rdata;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write_a(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus_a.acq_waddr = addr;
        bus_a.acq_wdata = data;
        bus_a.acq_wen   = 1'b1;
        tick();
        bus_a.acq_wen   = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        int n0;
        rst_n = 1'b0;
        repeat (3) tick();
        total++;
        if ({a_ce_n, a_we_n, a_oe_n, a_doe, bus_a.host_rack, bus_a.host_rvalid, bus_a.wr_ovf} !== 7'b1110000)
            $display("FAIL reset_strobes: got %b exp 1110000",
                     {a_ce_n, a_we_n, a_oe_n, a_doe, bus_a.host_rack, bus_a.host_rvalid, bus_a.wr_ovf});
        else passed++;
        total++;
        if ({a_addr, a_dout, bus_a.host_rdata} !== '0)
            $display("FAIL reset_buses: addr %h dout %h rdata %h exp 0", a_addr, a_dout, bus_a.host_rdata);
        else passed++;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus_a.acq_waddr = AW'(32'h40 + i);
            bus_a.acq_wdata = DW'(32'h1100 + i);
            bus_a.acq_wen   = 1'b1;
            tick();
        end
        total++;
        if (a_we_n !== 1'b0) $display("FAIL burst_active_before_reset: we_n %b exp 0", a_we_n);
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if ({a_ce_n, a_we_n, a_oe_n, a_doe, bus_a.wr_ovf} !== 5'b11100)
            $display("FAIL async_reset: got %b exp 11100", {a_ce_n, a_we_n, a_oe_n, a_doe, bus_a.wr_ovf});
        else passed++;
        tick();
        bus_a.acq_wen = 1'b0;
        tick();
        rst_n = 1'b1;
        n0 = log_a.size();
        repeat (6) tick();
        total++;
        if (log_a.size() !== n0 || a_ce_n !== 1'b1)
            $display("FAIL fifo_flushed: writes %0d ce_n %b exp 0 writes ce_n 1", log_a.size() - n0, a_ce_n);
        else passed++;
    endtask

    task automatic test_burst();
        int n0;
        n0 = log_a.size();
        for (int i = 0; i < 100; i++) begin
            bus_a.acq_waddr = AW'(i);
            bus_a.acq_wdata = DW'(32'h200 + i);
            bus_a.acq_wen   = 1'b1;
            tick();
        end
        bus_a.acq_wen = 1'b0;
        repeat (5) tick();
        total++;
        if (log_a.size() !== n0 + 100) $display("FAIL burst_count: got %0d exp 100", log_a.size() - n0);
        else passed++;
        if (log_a.size() >= n0 + 100) begin
            for (int i = 0; i < 100; i++) begin
                total++;
                if (log_a[n0+i].a !== AW'(i) || log_a[n0+i].d !== DW'(32'h200 + i) ||
                    log_a[n0+i].c !== log_a[n0].c + i)
                    $display("FAIL burst_word%0d: addr %h data %h cyc+%0d exp %h %h +%0d", i,
                             log_a[n0+i].a, log_a[n0+i].d, log_a[n0+i].c - log_a[n0].c, i, 32'h200 + i, i);
                else passed++;
            end
        end
        total++;
        if (bus_a.wr_ovf !== 1'b0) $display("FAIL burst_ovf: got %b exp 0", bus_a.wr_ovf);
        else passed++;
    endtask

    task automatic test_read();
        int k;
        int m;
        write_a(AW'(32'h12345), 16'hABCD);
        bus_a.host_raddr = AW'(32'h12345);
        bus_a.host_rreq  = 1'b1;
        k = 0;
        while (k < 20) begin
            tick(); k++;
            if (bus_a.host_rack) break;
        end
        total++;
        if (k !== 1) $display("FAIL read_ack_latency: got %0d exp 1", k);
        else passed++;
        bus_a.host_rreq  = 1'b0;
        bus_a.host_raddr = '0;
        m = 0;
        while (m < 20) begin
            tick(); m++;
            if (bus_a.host_rack) begin
                total++;
                $display("FAIL read_ack_pulse: ack high %0d clks after grant exp 0", m);
            end
            if (bus_a.host_rvalid) break;
        end
        total++;
        if (m !== 3) $display("FAIL read_valid_latency: got %0d exp 3", m);
        else passed++;
        total++;
        if (bus_a.host_rdata !== 16'hABCD) $display("FAIL read_data: got %h exp abcd", bus_a.host_rdata);
        else passed++;
        tick();
        total++;
        if (bus_a.host_rvalid !== 1'b0) $display("FAIL read_valid_pulse: got %b exp 0", bus_a.host_rvalid);
        else passed++;
    endtask

    task automatic test_collision();
        int k;
        int n0;
        int rv0;
        write_a(AW'(32'h100), 16'h5555);
        n0  = log_a.size();
        rv0 = rv_cnt_a;
        bus_a.host_raddr = AW'(32'h100);
        bus_a.host_rreq  = 1'b1;
        k = 0;
        while (k < 20) begin
            tick(); k++;
            if (bus_a.host_rack) break;
        end
        total++;
        if (k !== 1) $display("FAIL coll_ack_latency: got %0d exp 1", k);
        else passed++;
        bus_a.host_rreq = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus_a.acq_waddr = AW'(32'h1000 + i);
            bus_a.acq_wdata = DW'(32'h7000 + i);
            bus_a.acq_wen   = 1'b1;
            tick();
        end
        bus_a.acq_wen = 1'b0;
        repeat (10) tick();
        total++;
        if (rv_cnt_a !== rv0 + 1 || rv_data_a !== 16'h5555)
            $display("FAIL coll_read: valids %0d data %h exp 1 5555", rv_cnt_a - rv0, rv_data_a);
        else passed++;
        total++;
        if (log_a.size() !== n0 + 20) $display("FAIL coll_count: got %0d exp 20", log_a.size() - n0);
        else passed++;
        if (log_a.size() >= n0 + 20) begin
            total++;
            if (log_a[n0].c !== rv_cyc_a + 1)
                $display("FAIL coll_first_write: at rvalid+%0d exp +1", log_a[n0].c - rv_cyc_a);
            else passed++;
            for (int i = 0; i < 20; i++) begin
                total++;
                if (log_a[n0+i].a !== AW'(32'h1000 + i) || log_a[n0+i].d !== DW'(32'h7000 + i))
                    $display("FAIL coll_word%0d: addr %h data %h exp %h %h", i,
                             log_a[n0+i].a, log_a[n0+i].d, 32'h1000 + i, 32'h7000 + i);
                else passed++;
            end
        end
        total++;
        if (viol_a !== 0) $display("FAIL bus_turnaround: violations %0d exp 0", viol_a);
        else passed++;
        total++;
        if (bus_a.wr_ovf !== 1'b0) $display("FAIL coll_ovf: got %b exp 0", bus_a.wr_ovf);
        else passed++;
    endtask

    task automatic test_lock();
        int hits;
        int k;
        int m;
        hits = 0;
        bus_a.acq_busy   = 1'b1;
        bus_a.host_raddr = AW'(32'h12345);
        bus_a.host_rreq  = 1'b1;
        repeat (10) begin
            tick();
            if (bus_a.host_rack) hits++;
        end
        total++;
        if (hits !== 0) $display("FAIL lock_no_ack: acks %0d exp 0", hits);
        else passed++;
        bus_a.acq_busy = 1'b0;
        k = 0;
        while (k < 20) begin
            tick(); k++;
            if (bus_a.host_rack) break;
        end
        total++;
        if (k !== 1) $display("FAIL lock_release_ack: got %0d exp 1", k);
        else passed++;
        bus_a.host_rreq = 1'b0;
        m = 0;
        while (m < 20) begin
            tick(); m++;
            if (bus_a.host_rvalid) break;
        end
        total++;
        if (m !== 3 || bus_a.host_rdata !== 16'hABCD)
            $display("FAIL lock_read: latency %0d data %h exp 3 abcd", m, bus_a.host_rdata);
        else passed++;
    endtask

    task automatic test_overflow();
        int k;
        int exp_idx [5];
        exp_idx = '{0, 1, 5, 6, 7};
        total++;
        if (bus_b.wr_ovf !== 1'b0) $display("FAIL ovf_initial: got %b exp 0", bus_b.wr_ovf);
        else passed++;
        bus_b.host_raddr = AW'(32'h10);
        bus_b.host_rreq  = 1'b1;
        k = 0;
        while (k < 20) begin
            tick(); k++;
            if (bus_b.host_rack) break;
        end
        total++;
        if (k !== 1) $display("FAIL ovf_ack_latency: got %0d exp 1", k);
        else passed++;
        bus_b.host_rreq = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_b.acq_waddr = AW'(32'h300 + i);
            bus_b.acq_wdata = DW'(32'h900 + i);
            bus_b.acq_wen   = 1'b1;
            tick();
        end
        bus_b.acq_wen = 1'b0;
        total++;
        if (bus_b.wr_ovf !== 1'b1) $display("FAIL ovf_set: got %b exp 1", bus_b.wr_ovf);
        else passed++;
        repeat (12) tick();
        total++;
        if (log_b.size() !== 5) $display("FAIL ovf_count: got %0d exp 5", log_b.size());
        else passed++;
        if (log_b.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (log_b[i].a !== AW'(32'h300 + exp_idx[i]) || log_b[i].d !== DW'(32'h900 + exp_idx[i]))
                    $display("FAIL ovf_word%0d: addr %h data %h exp %h %h", i, log_b[i].a, log_b[i].d,
                             32'h300 + exp_idx[i], 32'h900 + exp_idx[i]);
                else passed++;
            end
        end
        total++;
        if (bus_b.wr_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b exp 1", bus_b.wr_ovf);
        else passed++;
        bus_b.ovf_clr = 1'b1;
        tick();
        bus_b.ovf_clr = 1'b0;
        total++;
        if (bus_b.wr_ovf !== 1'b0) $display("FAIL ovf_clear: got %b exp 0", bus_b.wr_ovf);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        rst_n            = 1'b0;
        bus_a.acq_waddr  = '0;
        bus_a.acq_wdata  = '0;
        bus_a.acq_wen    = 1'b0;
        bus_a.acq_busy   = 1'b0;
        bus_a.host_rreq  = 1'b0;
        bus_a.host_raddr = '0;
        bus_a.ovf_clr    = 1'b0;
        bus_b.acq_waddr  = '0;
        bus_b.acq_wdata  = '0;
        bus_b.acq_wen    = 1'b0;
        bus_b.acq_busy   = 1'b0;
        bus_b.host_rreq  = 1'b0;
        bus_b.host_raddr = '0;
        bus_b.ovf_clr    = 1'b0;
        test_reset();
        test_burst();
        test_read();
        test_collision();
        test_lock();
        test_overflow();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

`default_nettype wire
